// File: rtl/axi_ad9144_tx_seq_pkg.sv
// rtl/axi_ad9144_tx_seq_pkg.sv - shared state encoding and widths for the AD9144 TX sequencer
package axi_ad9144_tx_seq_pkg;

   localparam int STATE_W   = 3;
   localparam int CH_DATA_W = 64;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LINK = 3'd1,
      ST_ARMED     = 3'd2,
      ST_PRIME     = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd5
   } seq_state_e;

   // States in which the DMA is asked for data.
   function automatic logic is_streaming(input seq_state_e s);
      return (s == ST_PRIME) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/axi_ad9144_tx_seq_trig_sync.sv
// rtl/axi_ad9144_tx_seq_trig_sync.sv - 2-flop synchronizer and rising-edge detect for ext_trig
module axi_ad9144_tx_seq_trig_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic trig_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= trig_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/axi_ad9144_tx_sequencer.sv
// rtl/axi_ad9144_tx_sequencer.sv - start/stop sequencer for the AD9144 JESD TX datapath
// Define AXI_AD9144_TX_SEQ_UNF_CNT_EN to add the stat_unf_count underflow total output.
module axi_ad9144_tx_sequencer #(
   parameter int NUM_CHANNELS       = 4,
   parameter int DATA_WIDTH         = 256,
   parameter int LINK_STABLE_CYCLES = 16,
   parameter int PRIME_CYCLES       = 4,
   parameter int UNF_LIMIT          = 8
) (
   input  logic                    dac_clk,
   input  logic                    dac_rst,
   input  logic                    cfg_start,
   input  logic                    cfg_stop,
   input  logic                    cfg_sync_en,
   input  logic                    cfg_fault_clr,
   input  logic [NUM_CHANNELS-1:0] cfg_enable,
   input  logic                    ext_trig,
   input  logic                    tx_ready,
   input  logic                    dac_dunf,
   input  logic [DATA_WIDTH-1:0]   dac_ddata,
`ifdef AXI_AD9144_TX_SEQ_UNF_CNT_EN
   output logic [15:0]             stat_unf_count,
`endif
   output logic [NUM_CHANNELS-1:0] dac_valid,
   output logic                    tx_valid,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic [2:0]              stat_state,
   output logic                    stat_link_lost,
   output logic                    stat_fault
);
   import axi_ad9144_tx_seq_pkg::*;

   localparam int LINK_W  = $clog2(LINK_STABLE_CYCLES) + 1;
   localparam int PRIME_W = $clog2(PRIME_CYCLES) + 1;
   localparam int UNF_W   = $clog2(UNF_LIMIT) + 1;

   localparam logic [LINK_W-1:0]  LINK_LAST  = LINK_W'(LINK_STABLE_CYCLES - 1);
   localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYCLES - 1);
   localparam logic [UNF_W-1:0]   UNF_LAST   = UNF_W'(UNF_LIMIT - 1);

   seq_state_e                state_q, state_d;
   logic [LINK_W-1:0]         link_cnt_q, link_cnt_d;
   logic [PRIME_W-1:0]        prime_cnt_q, prime_cnt_d;
   logic [UNF_W-1:0]          unf_cnt_q, unf_cnt_d;
   logic                      link_lost_q, link_lost_d;
   logic [NUM_CHANNELS-1:0]   dac_valid_q;
   logic                      tx_valid_q;
   logic [DATA_WIDTH-1:0]     tx_data_q;
   logic                      fault_q;
   logic [DATA_WIDTH-1:0]     en_mask;
   logic                      trig_rise;
   logic                      start_ok;

   axi_ad9144_tx_seq_trig_sync u_trig_sync (
      .clk_i  (dac_clk),
      .rst_i  (dac_rst),
      .trig_i (ext_trig),
      .rise_o (trig_rise)
   );

   // A disabled channel's 64b slice never reaches the link.
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_mask
      assign en_mask[c*CH_DATA_W +: CH_DATA_W] = {CH_DATA_W{cfg_enable[c]}};
   end

   assign start_ok = (state_q == ST_IDLE) && cfg_start && !cfg_stop;

   always_comb begin
      state_d     = state_q;
      link_cnt_d  = link_cnt_q;
      prime_cnt_d = prime_cnt_q;
      unf_cnt_d   = unf_cnt_q;
      link_lost_d = link_lost_q;

      if (state_q != ST_IDLE && cfg_stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  state_d     = ST_WAIT_LINK;
                  link_lost_d = 1'b0;
               end
            end
            ST_WAIT_LINK: begin
               if (!tx_ready) begin
                  link_cnt_d = '0;
               end else if (link_cnt_q == LINK_LAST) begin
                  state_d = cfg_sync_en ? ST_ARMED : ST_PRIME;
               end else begin
                  link_cnt_d = link_cnt_q + 1'b1;
               end
            end
            ST_ARMED: begin
               if (!tx_ready) begin
                  state_d = ST_WAIT_LINK;
               end else if (trig_rise) begin
                  state_d = ST_PRIME;
               end
            end
            ST_PRIME: begin
               if (!tx_ready) begin
                  state_d     = ST_WAIT_LINK;
                  link_lost_d = 1'b1;
               end else if (prime_cnt_q == PRIME_LAST) begin
                  state_d = ST_RUN;
               end else begin
                  prime_cnt_d = prime_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!tx_ready) begin
                  state_d     = ST_WAIT_LINK;
                  link_lost_d = 1'b1;
               end else if (dac_dunf) begin
                  if (unf_cnt_q == UNF_LAST) begin
                     state_d = ST_FAULT;
                  end else begin
                     unf_cnt_d = unf_cnt_q + 1'b1;
                  end
               end else begin
                  unf_cnt_d = '0;
               end
            end
            ST_FAULT: begin
               if (cfg_fault_clr) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Every state entry starts its counters from zero.
      if (state_d != state_q) begin
         link_cnt_d  = '0;
         prime_cnt_d = '0;
         unf_cnt_d   = '0;
      end
   end

   // Outputs are derived from the next state so they line up with stat_state.
   always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
         state_q     <= ST_IDLE;
         link_cnt_q  <= '0;
         prime_cnt_q <= '0;
         unf_cnt_q   <= '0;
         link_lost_q <= 1'b0;
         dac_valid_q <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         link_cnt_q  <= link_cnt_d;
         prime_cnt_q <= prime_cnt_d;
         unf_cnt_q   <= unf_cnt_d;
         link_lost_q <= link_lost_d;
         dac_valid_q <= is_streaming(state_d) ? (cfg_enable & {NUM_CHANNELS{tx_ready}}) : '0;
         tx_valid_q  <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
         fault_q     <= (state_d == ST_FAULT);
         if (state_q == ST_RUN && state_d == ST_RUN && !dac_dunf) begin
            tx_data_q <= dac_ddata & en_mask;
         end else begin
            tx_data_q <= '0;
         end
      end
   end

`ifdef AXI_AD9144_TX_SEQ_UNF_CNT_EN
   logic [15:0] unf_total_q;

   always_ff @(posedge dac_clk) begin
      if (dac_rst || start_ok) begin
         unf_total_q <= '0;
      end else if (state_q == ST_RUN && dac_dunf && unf_total_q != 16'hffff) begin
         unf_total_q <= unf_total_q + 16'd1;
      end
   end

   assign stat_unf_count = unf_total_q;
`endif

   assign dac_valid      = dac_valid_q;
   assign tx_valid       = tx_valid_q;
   assign tx_data        = tx_data_q;
   assign stat_state     = state_q;
   assign stat_link_lost = link_lost_q;
   assign stat_fault     = fault_q;

endmodule

// File: tb/tb_axi_ad9144_tx_sequencer.sv
// tb/tb_axi_ad9144_tx_sequencer.sv - directed bench with random data for axi_ad9144_tx_sequencer
module tb_axi_ad9144_tx_sequencer;

   logic         dac_clk = 1'b0;
   logic         dac_rst;
   logic         cfg_start, cfg_stop, cfg_sync_en, cfg_fault_clr;
   logic [3:0]   cfg_enable;
   logic         ext_trig, tx_ready, dac_dunf;
   logic [255:0] dac_ddata;
   logic [3:0]   dac_valid;
   logic         tx_valid;
   logic [255:0] tx_data;
   logic [2:0]   stat_state;
   logic         stat_link_lost, stat_fault;
`ifdef AXI_AD9144_TX_SEQ_UNF_CNT_EN
   logic [15:0]  stat_unf_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 dac_clk = ~dac_clk;

   axi_ad9144_tx_sequencer dut (
      .dac_clk        (dac_clk),
      .dac_rst        (dac_rst),
      .cfg_start      (cfg_start),
      .cfg_stop       (cfg_stop),
      .cfg_sync_en    (cfg_sync_en),
      .cfg_fault_clr  (cfg_fault_clr),
      .cfg_enable     (cfg_enable),
      .ext_trig       (ext_trig),
      .tx_ready       (tx_ready),
      .dac_dunf       (dac_dunf),
      .dac_ddata      (dac_ddata),
`ifdef AXI_AD9144_TX_SEQ_UNF_CNT_EN
      .stat_unf_count (stat_unf_count),
`endif
      .dac_valid      (dac_valid),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .stat_state     (stat_state),
      .stat_link_lost (stat_link_lost),
      .stat_fault     (stat_fault)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mask_of(input logic [3:0] en);
      logic [255:0] m;
      m = '0;
      for (int c = 0; c < 4; c++) if (en[c]) m[c*64 +: 64] = {64{1'b1}};
      return m;
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic tick();
      @(posedge dac_clk);
      #1;
   endtask

   task automatic count_state(input logic [2:0] st, output int n);
      n = 0;
      while (stat_state === st && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic start_seq(input logic sync);
      cfg_sync_en = sync;
      cfg_start   = 1'b1;
      tick();
      cfg_start   = 1'b0;
      chk("start_to_wait_link", 256'(stat_state), 256'(1));
   endtask

   // Start with sync disabled and walk WAIT_LINK and PRIME into RUN.
   task automatic go_run(input string tag);
      int n;
      start_seq(1'b0);
      count_state(3'd1, n);
      chk({tag, "_link_len"}, 256'(n), 256'(16));
      chk({tag, "_prime_entry"}, 256'(stat_state), 256'(3));
      chk({tag, "_prime_valid"}, 256'(dac_valid), 256'(cfg_enable));
      n = 0;
      while (stat_state === 3'd3 && n < 50) begin
         chk({tag, "_prime_muted"}, tx_data, 256'(0));
         dac_ddata = rnd256();
         tick();
         n++;
      end
      chk({tag, "_prime_len"}, 256'(n), 256'(4));
      chk({tag, "_run_entry"}, 256'(stat_state), 256'(4));
      chk({tag, "_run_first_zero"}, tx_data, 256'(0));
   endtask

   // Reference: each word leaves one cycle later, masked by enables, zeroed on underflow.
   task automatic stream(input string tag, input int cyc, input logic dunf);
      logic [255:0] d, e;
      for (int i = 0; i < cyc; i++) begin
         d         = rnd256();
         dac_ddata = d;
         dac_dunf  = dunf;
         e         = dunf ? 256'(0) : (d & mask_of(cfg_enable));
         tick();
         chk({tag, "_data"}, tx_data, e);
         chk({tag, "_state"}, 256'(stat_state), 256'(4));
      end
      dac_dunf = 1'b0;
   endtask

   task automatic stop_seq(input string tag);
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
      chk({tag, "_stop_idle"}, 256'(stat_state), 256'(0));
      chk({tag, "_stop_txv"}, 256'(tx_valid), 256'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      dac_rst = 1'b1;
      cfg_start = 1'b0; cfg_stop = 1'b0; cfg_sync_en = 1'b0; cfg_fault_clr = 1'b0;
      cfg_enable = 4'hf; ext_trig = 1'b0; tx_ready = 1'b1; dac_dunf = 1'b0; dac_ddata = '0;
      tick();
      tick();
      dac_rst = 1'b0;
      chk("rst_state", 256'(stat_state), 256'(0));
      chk("rst_dac_valid", 256'(dac_valid), 256'(0));
      chk("rst_tx_valid", 256'(tx_valid), 256'(0));
      chk("rst_tx_data", tx_data, 256'(0));
      chk("rst_link_lost", 256'(stat_link_lost), 256'(0));
      chk("rst_fault", 256'(stat_fault), 256'(0));

      // 1: basic bring-up and 1-cycle data echo
      go_run("t1");
      chk("t1_txv", 256'(tx_valid), 256'(1));
      stream("t1", 8, 1'b0);
      stop_seq("t1");

      // 2: external trigger arming
      start_seq(1'b1);
      count_state(3'd1, n);
      chk("t2_link_len", 256'(n), 256'(16));
      chk("t2_armed", 256'(stat_state), 256'(2));
      chk("t2_armed_dv", 256'(dac_valid), 256'(0));
      n = 0;
      repeat (100) begin
         tick();
         if (stat_state === 3'd2) n++;
      end
      chk("t2_armed_hold", 256'(n), 256'(100));
      ext_trig = 1'b1;
      count_state(3'd2, n);
      chk("t2_trig_latency", 256'(n >= 3 && n <= 4), 256'(1));
      chk("t2_prime", 256'(stat_state), 256'(3));
      ext_trig = 1'b0;
      stop_seq("t2");

      // 3: underflow tolerance and fault
      cfg_enable = 4'hf;
      go_run("t3");
      stream("t3_unf7", 7, 1'b1);
      stream("t3_clean", 1, 1'b0);
      stream("t3_unf7b", 7, 1'b1);
      dac_dunf = 1'b1;
      tick();
      dac_dunf = 1'b0;
      chk("t3_fault_state", 256'(stat_state), 256'(5));
      chk("t3_fault_flag", 256'(stat_fault), 256'(1));
      chk("t3_fault_dv", 256'(dac_valid), 256'(0));
      chk("t3_fault_txv", 256'(tx_valid), 256'(0));
      chk("t3_fault_data", tx_data, 256'(0));
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("t3_start_ignored", 256'(stat_state), 256'(5));
      cfg_fault_clr = 1'b1;
      tick();
      cfg_fault_clr = 1'b0;
      chk("t3_clr_idle", 256'(stat_state), 256'(0));
      chk("t3_clr_flag", 256'(stat_fault), 256'(0));

      // 4: link loss in RUN, relock, sticky flag, glitch during WAIT_LINK
      cfg_enable = 4'($urandom_range(1, 15));
      go_run("t4");
      stream("t4", 3, 1'b0);
      tx_ready  = 1'b0;
      dac_ddata = rnd256();
      tick();
      tx_ready  = 1'b1;
      chk("t4_lost_state", 256'(stat_state), 256'(1));
      chk("t4_lost_flag", 256'(stat_link_lost), 256'(1));
      chk("t4_lost_mute", tx_data, 256'(0));
      chk("t4_lost_dv", 256'(dac_valid), 256'(0));
      count_state(3'd1, n);
      chk("t4_relock_len", 256'(n), 256'(16));
      chk("t4_relock_prime", 256'(stat_state), 256'(3));
      stop_seq("t4");
      chk("t4_sticky", 256'(stat_link_lost), 256'(1));
      start_seq(1'b0);
      chk("t4_start_clears", 256'(stat_link_lost), 256'(0));
      repeat (10) tick();
      tx_ready = 1'b0;
      tick();
      tx_ready = 1'b1;
      count_state(3'd1, n);
      chk("t4_glitch_restart", 256'(n), 256'(16));
      stop_seq("t4b");

      // 5: stop priority
      cfg_start = 1'b1;
      cfg_stop  = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      chk("t5_start_stop_idle", 256'(stat_state), 256'(0));
      start_seq(1'b0);
      count_state(3'd1, n);
      chk("t5_prime", 256'(stat_state), 256'(3));
      tick();
      stop_seq("t5");
      chk("t5_stop_dv", 256'(dac_valid), 256'(0));

      // 6: partial channel enable, underflow count, reset mid-stream
      cfg_enable = 4'b0101;
      go_run("t6");
      chk("t6_dv", 256'(dac_valid), 256'(4'b0101));
      stream("t6_pre", 3, 1'b0);
      stream("t6_unf", 5, 1'b1);
      stream("t6_post", 2, 1'b0);
`ifdef AXI_AD9144_TX_SEQ_UNF_CNT_EN
      chk("t6_unf_count", 256'(stat_unf_count), 256'(5));
`endif
      dac_rst = 1'b1;
      tick();
      dac_rst = 1'b0;
      chk("t6_rst_state", 256'(stat_state), 256'(0));
      chk("t6_rst_data", tx_data, 256'(0));
      chk("t6_rst_txv", 256'(tx_valid), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
